// File: rtl/alu_pkg.sv
// alu_pkg: shared constants, decoded control codes, FSM state encoding and the
// ALUOp/funct decoder for alu_exec_unit.
// Optional feature macro: ALU_DIV_EN (div/divu decode as legal only when defined).
package alu_pkg;

    localparam int ALU_CTRL_W = 5;

    // ALUOp field from the main decoder
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_XOR   = 3'b101;
    localparam logic [2:0] OP_SLT   = 3'b110;

    // R-type funct field
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Internal control code; CTRL_NOP doubles as the code for illegal ops
    typedef enum logic [ALU_CTRL_W-1:0] {
        CTRL_NOP = 5'd0,
        CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR, CTRL_XOR, CTRL_NOR,
        CTRL_SLT, CTRL_SLTU, CTRL_SLL, CTRL_SRL, CTRL_SRA,
        CTRL_MFHI, CTRL_MFLO, CTRL_MULT, CTRL_MULTU, CTRL_DIV, CTRL_DIVU
    } alu_ctrl_e;

    // FSM state encoding
    typedef logic [1:0] alu_state_t;
    localparam alu_state_t ST_IDLE = 2'd0;
    localparam alu_state_t ST_MUL  = 2'd1;
`ifdef ALU_DIV_EN
    localparam alu_state_t ST_DIV  = 2'd2;
`endif

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      illegal;
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [2:0] aluop, input logic [5:0] funct);
        alu_dec_t d;
        d.ctrl    = CTRL_NOP;
        d.illegal = 1'b0;
        case (aluop)
            OP_ADD: d.ctrl = CTRL_ADD;
            OP_SUB: d.ctrl = CTRL_SUB;
            OP_AND: d.ctrl = CTRL_AND;
            OP_OR:  d.ctrl = CTRL_OR;
            OP_XOR: d.ctrl = CTRL_XOR;
            OP_SLT: d.ctrl = CTRL_SLT;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: d.ctrl = CTRL_ADD;
                    FN_SUB, FN_SUBU: d.ctrl = CTRL_SUB;
                    FN_AND:          d.ctrl = CTRL_AND;
                    FN_OR:           d.ctrl = CTRL_OR;
                    FN_XOR:          d.ctrl = CTRL_XOR;
                    FN_NOR:          d.ctrl = CTRL_NOR;
                    FN_SLT:          d.ctrl = CTRL_SLT;
                    FN_SLTU:         d.ctrl = CTRL_SLTU;
                    FN_SLL:          d.ctrl = CTRL_SLL;
                    FN_SRL:          d.ctrl = CTRL_SRL;
                    FN_SRA:          d.ctrl = CTRL_SRA;
                    FN_MFHI:         d.ctrl = CTRL_MFHI;
                    FN_MFLO:         d.ctrl = CTRL_MFLO;
                    FN_MULT:         d.ctrl = CTRL_MULT;
                    FN_MULTU:        d.ctrl = CTRL_MULTU;
`ifdef ALU_DIV_EN
                    FN_DIV:          d.ctrl = CTRL_DIV;
                    FN_DIVU:         d.ctrl = CTRL_DIVU;
`endif
                    default:         d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: one-bit-per-cycle shift-add multiplier / restoring divider.
// The first step runs on the start edge itself, so W steps finish W-1 cycles
// later and done pulses for one cycle with hi/lo already sign-corrected.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_div,
    input  logic         is_signed,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W) + 1;

    logic          busy;
    logic          div_mode;
    logic          neg_lo;     // product sign (mult) or quotient sign (div)
    logic          neg_hi;     // remainder takes the dividend's sign
    logic          div0;
    logic [CW-1:0] cnt;
    logic [W:0]    acc;        // upper product half / partial remainder
    logic [W-1:0]  q;          // multiplier bits shifting out / quotient shifting in
    logic [W-1:0]  opnd;       // multiplicand or divisor magnitude
    logic [W-1:0]  a_orig;

    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     st_acc;
    logic [W-1:0]   st_q, st_op;
    logic           st_div;
    logic [W:0]     sum, shifted, trial;
    logic [W:0]     nxt_acc;
    logic [W-1:0]   nxt_q;
    logic [2*W-1:0] prod, prod_fix;

    assign mag_a = (is_signed && a[W-1]) ? -a : a;
    assign mag_b = (is_signed && b[W-1]) ? -b : b;

    // On the start cycle the step works straight from the operands
    assign st_acc = start ? '0 : acc;
    assign st_q   = start ? mag_a : q;
    assign st_op  = start ? mag_b : opnd;
    assign st_div = start ? is_div : div_mode;

    assign sum     = st_q[0] ? (st_acc + {1'b0, st_op}) : st_acc;
    assign shifted = {st_acc[W-1:0], st_q[W-1]};
    assign trial   = shifted - {1'b0, st_op};

    // One iteration step: restoring-divide subtract or shift-add multiply
    always_comb begin
        // NOTE: every output gets a value on every path so no latch is inferred.
        nxt_acc = {1'b0, sum[W:1]};
        nxt_q   = {sum[0], st_q[W-1:1]};
        if (st_div) begin
            if (!trial[W]) begin
                nxt_acc = trial;
                nxt_q   = {st_q[W-2:0], 1'b1};
            end else begin
                nxt_acc = shifted;
                nxt_q   = {st_q[W-2:0], 1'b0};
            end
        end
    end

    // Iteration registers and step counter
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_mode <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div0     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            opnd     <= '0;
            a_orig   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc      <= nxt_acc;
                q        <= nxt_q;
                opnd     <= mag_b;
                div_mode <= is_div;
                neg_lo   <= is_signed && (a[W-1] ^ b[W-1]);
                neg_hi   <= is_signed && is_div && a[W-1];
                div0     <= is_div && (b == '0);
                a_orig   <= a;
                cnt      <= CW'(W - 1);
                busy     <= 1'b1;
            end else if (busy) begin
                acc <= nxt_acc;
                q   <= nxt_q;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign prod     = {acc[W-1:0], q};
    assign prod_fix = neg_lo ? -prod : prod;

    // Sign fixup and divide-by-zero override of the final registers
    always_comb begin
        hi = prod_fix[2*W-1:W];
        lo = prod_fix[W-1:0];
        if (div_mode) begin
            if (div0) begin
                lo = '1;
                hi = a_orig;
            end else begin
                lo = neg_lo ? -q : q;
                hi = neg_hi ? -acc[W-1:0] : acc[W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with valid/ready on both sides, single-cycle
// ALU ops and an iterative multiply (and optional divide) unit feeding HI/LO.
// Optional feature macro: ALU_DIV_EN (adds div/divu and the DIV state).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int W      = 32,
    parameter int CTRL_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           aluop,
    input  logic [5:0]           funct,
    input  logic [$clog2(W)-1:0] shamt,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         result,
    output logic                 zero,
    output logic [W-1:0]         hi,
    output logic [W-1:0]         lo,
    output logic                 illegal,
    output logic [CTRL_W-1:0]    ctrl_o
);

    alu_state_t   state;
    alu_dec_t     dec;
    logic         accept;
    logic         is_mul, is_div, is_signed;
    logic         mdu_start, mdu_done;
    logic [W-1:0] mdu_hi, mdu_lo;
    logic [W-1:0] alu_res;

    assign dec       = alu_decode(aluop, funct);
    assign in_ready  = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (dec.ctrl == CTRL_MULT) || (dec.ctrl == CTRL_MULTU);
`ifdef ALU_DIV_EN
    assign is_div    = (dec.ctrl == CTRL_DIV) || (dec.ctrl == CTRL_DIVU);
`else
    assign is_div    = 1'b0;
`endif
    assign is_signed = (dec.ctrl == CTRL_MULT) || (dec.ctrl == CTRL_DIV);
    assign mdu_start = accept && (is_mul || is_div);

    alu_mdu_iter #(.W(W)) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .start     (mdu_start),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .done      (mdu_done),
        .hi        (mdu_hi),
        .lo        (mdu_lo)
    );

    // Single-cycle datapath; mfhi/mflo read the architectural registers
    always_comb begin
        alu_res = '0;
        case (dec.ctrl)
            CTRL_ADD:  alu_res = a + b;
            CTRL_SUB:  alu_res = a - b;
            CTRL_AND:  alu_res = a & b;
            CTRL_OR:   alu_res = a | b;
            CTRL_XOR:  alu_res = a ^ b;
            CTRL_NOR:  alu_res = ~(a | b);
            CTRL_SLT:  alu_res = W'($signed(a) < $signed(b));
            CTRL_SLTU: alu_res = W'(a < b);
            CTRL_SLL:  alu_res = b << shamt;
            CTRL_SRL:  alu_res = b >> shamt;
            CTRL_SRA:  alu_res = $signed(b) >>> shamt;
            CTRL_MFHI: alu_res = hi;
            CTRL_MFLO: alu_res = lo;
            default:   alu_res = '0;
        endcase
    end

    // Handshake, FSM, output and HI/LO registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            hi        <= '0;
            lo        <= '0;
            illegal   <= 1'b0;
            ctrl_o    <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ctrl_o  <= CTRL_W'(dec.ctrl);
                        illegal <= dec.illegal;
                        if (is_mul || is_div) begin
                            result <= '0;
                            zero   <= 1'b1;
`ifdef ALU_DIV_EN
                            state  <= is_mul ? ST_MUL : ST_DIV;
`else
                            state  <= ST_MUL;
`endif
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
`ifdef ALU_DIV_EN
                ST_MUL, ST_DIV: begin
`else
                ST_MUL: begin
`endif
                    if (mdu_done) begin
                        hi        <= mdu_hi;
                        lo        <= mdu_lo;
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (W=32).
// Expected outputs are computed by a reference model when each op is issued
// and popped when the DUT presents a result.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   aluop;
    logic [5:0]   funct;
    logic [4:0]   shamt;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] hi, lo;
    logic         illegal;
    logic [4:0]   ctrl_o;

    always #5 clk = ~clk;

    alu_exec_unit #(.W(W), .CTRL_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .funct     (funct),
        .shamt     (shamt),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .hi        (hi),
        .lo        (lo),
        .illegal   (illegal),
        .ctrl_o    (ctrl_o)
    );

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         illegal;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_hi, m_lo;
    int           n_checks = 0;
    int           n_fail   = 0;

    // Reference model: computes the expected output and tracks HI/LO
    task automatic push_expect(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                               input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t            e;
        logic [W-1:0]    r;
        logic            ill;
        longint          sx, sy, sp;
        longint unsigned ux, uy, up;
        int              dx, dy;
        r   = '0;
        ill = 1'b0;
        case (op)
            3'b000: r = x + y;
            3'b001: r = x - y;
            3'b011: r = x & y;
            3'b100: r = x | y;
            3'b101: r = x ^ y;
            3'b110: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b010: begin
                case (fn)
                    6'b100000, 6'b100001: r = x + y;
                    6'b100010, 6'b100011: r = x - y;
                    6'b100100: r = x & y;
                    6'b100101: r = x | y;
                    6'b100110: r = x ^ y;
                    6'b100111: r = ~(x | y);
                    6'b101010: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                    6'b101011: r = (x < y) ? 32'd1 : 32'd0;
                    6'b000000: r = y << sh;
                    6'b000010: r = y >> sh;
                    6'b000011: r = (y >> sh) | (y[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                    6'b010000: r = m_hi;
                    6'b010010: r = m_lo;
                    6'b011000: begin
                        sx = $signed(x); sy = $signed(y); sp = sx * sy;
                        m_hi = sp[63:32]; m_lo = sp[31:0];
                    end
                    6'b011001: begin
                        ux = x; uy = y; up = ux * uy;
                        m_hi = up[63:32]; m_lo = up[31:0];
                    end
`ifdef ALU_DIV_EN
                    6'b011010: begin
                        dx = $signed(x); dy = $signed(y);
                        if (y == 0) begin m_lo = '1; m_hi = x; end
                        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin m_lo = x; m_hi = '0; end
                        else begin m_lo = dx / dy; m_hi = dx % dy; end
                    end
                    6'b011011: begin
                        if (y == 0) begin m_lo = '1; m_hi = x; end
                        else begin m_lo = x / y; m_hi = x % y; end
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        e.result  = r;
        e.zero    = (r == 0);
        e.illegal = ill;
        e.hi      = m_hi;
        e.lo      = m_lo;
        sb.push_back(e);
    endtask

    // Present one op, hold it until accepted, then record its expectation
    task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(negedge clk);
        aluop = op; funct = fn; shamt = sh; a = x; b = y;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            push_expect(op, fn, sh, x, y);
        end
    endtask

    // Wait (bounded) for out_valid; returns observed outputs, expectation and wait length
    task automatic get_out(output exp_t got, output exp_t e, output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (out_valid) got = {result, zero, illegal, hi, lo};
        else           got = 'x;
        if (sb.size() > 0) e = sb.pop_front();
        else               e = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluop = '0; funct = '0; shamt = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b required 0", in_ready);
        end
        n_checks++;
        if ({out_valid, result, zero, hi, lo, illegal, ctrl_o} !== {1'b0, 32'd0, 1'b1, 32'd0, 32'd0, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: ov=%0b res=%h z=%0b hi=%h lo=%h ill=%0b ctrl=%0d required 0,0,1,0,0,0,0",
                     out_valid, result, zero, hi, lo, illegal, ctrl_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_alu_ops();
        logic [8:0]   tbl [19];
        exp_t         got, e;
        int           lat;
        logic [W-1:0] x, y;
        logic [5:0]   fn;
        tbl = '{{3'b000, 6'd0}, {3'b001, 6'd0}, {3'b011, 6'd0}, {3'b100, 6'd0}, {3'b101, 6'd0},
                {3'b110, 6'd0}, {3'b010, 6'b100000}, {3'b010, 6'b100001}, {3'b010, 6'b100010},
                {3'b010, 6'b100011}, {3'b010, 6'b100100}, {3'b010, 6'b100101}, {3'b010, 6'b100110},
                {3'b010, 6'b100111}, {3'b010, 6'b101010}, {3'b010, 6'b101011}, {3'b010, 6'b000000},
                {3'b010, 6'b000010}, {3'b010, 6'b000011}};
        for (int i = 0; i < 19; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (k == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                else begin x = $urandom; y = $urandom; end
                fn = (tbl[i][8:6] == 3'b010) ? tbl[i][5:0] : 6'($urandom_range(0, 63));
                issue(tbl[i][8:6], fn, 5'($urandom_range(0, 31)), x, y);
                get_out(got, e, lat);
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL alu_op op=%b fn=%b a=%h b=%h: got %h required %h",
                             tbl[i][8:6], fn, x, y, got, e);
                end
                n_checks++;
                if (lat !== 0) begin
                    n_fail++;
                    $display("FAIL alu_latency op=%b: got %0d extra cycles required 0", tbl[i][8:6], lat);
                end
            end
        end
    endtask

    task automatic test_sub_zero();
        exp_t got, e;
        int   lat;
        issue(3'b010, 6'b100010, 5'd0, 32'd5, 32'd7);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.result !== 32'hFFFF_FFFE || got.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_5_7: got %h required %h", got, e);
        end
        issue(3'b001, 6'd0, 5'd0, 32'h1234_5678, 32'h1234_5678);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.zero !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_equal_zero: got %h required %h", got, e);
        end
    endtask

    task automatic test_mult_mflo();
        exp_t got, e;
        int   lat;
        issue(3'b010, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'd4);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.hi !== 32'hFFFF_FFFF || got.lo !== 32'hFFFF_FFF4) begin
            n_fail++;
            $display("FAIL mult_neg3_4: got %h required %h", got, e);
        end
        n_checks++;
        if (lat !== W + 1) begin
            n_fail++;
            $display("FAIL mult_latency: got %0d cycles required %0d", lat, W + 1);
        end
        issue(3'b010, 6'b010010, 5'd0, 32'd0, 32'd0);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.result !== 32'hFFFF_FFF4) begin
            n_fail++;
            $display("FAIL mflo_after_mult: got %h required %h", got, e);
        end
        issue(3'b010, 6'b010000, 5'd0, 32'd0, 32'd0);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL mfhi_after_mult: got %h required %h", got, e);
        end
        issue(3'b010, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL multu_max: got %h required %h", got, e);
        end
        issue(3'b010, 6'b011000, 5'd0, 32'h8000_0000, 32'h8000_0000);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL mult_min_min: got %h required %h", got, e);
        end
    endtask

    task automatic test_div();
        exp_t         got, e;
        int           lat;
        logic [W-1:0] xs [4];
        logic [W-1:0] ys [4];
        logic [5:0]   fs [4];
        xs = '{32'hFFFF_FFF9, 32'd9, 32'h8000_0000, 32'd100};
        ys = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
        fs = '{6'b011010, 6'b011010, 6'b011010, 6'b011011};
        for (int i = 0; i < 4; i++) begin
            issue(3'b010, fs[i], 5'd0, xs[i], ys[i]);
            get_out(got, e, lat);
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL div_case%0d a=%h b=%h: got %h required %h", i, xs[i], ys[i], got, e);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t got, e;
        int   lat;
        issue(3'b010, 6'b111111, 5'd0, 32'd3, 32'd4);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_funct: got %h required %h", got, e);
        end
        issue(3'b111, 6'b100000, 5'd0, 32'd3, 32'd4);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_aluop: got %h required %h", got, e);
        end
    endtask

    task automatic test_backpressure();
        exp_t got, e;
        int   lat;
        int   bad;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'b110, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd1);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.result !== 32'd1) begin
            n_fail++;
            $display("FAIL slt_backpressure: got %h required %h", got, e);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'd1 || in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d unstable cycles (ov=%0b res=%h rdy=%0b) required 0",
                     bad, out_valid, result, in_ready);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release_backpressure: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t got, e;
        int   lat;
        int   seen;
        issue(3'b010, 6'b011001, 5'd0, 32'd7, 32'd9);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        rst = 1'b0;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_valid: out_valid seen %0d cycles required 0", seen);
        end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_hilo: hi=%h lo=%h required 0,0", hi, lo);
        end
        issue(3'b000, 6'd0, 5'd0, 32'd1, 32'd1);
        get_out(got, e, lat);
        n_checks++;
        if (got !== e || got.result !== 32'd2) begin
            n_fail++;
            $display("FAIL add_after_abort: got %h required %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_sub_zero();
        test_mult_mflo();
        test_div();
        test_illegal();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
